// File: rtl/muxer_4.sv
// Registered 4:1 single-bit multiplexer.
// The select tree is built from 2:1 cells: two leaf cells pick within each
// half of the input bus, and a root cell picks between the halves. The tree
// output is captured in a single register, so q is in[sel] one clock later.

// 2:1 mux cell: y follows d[1] when s is high, otherwise d[0].
module mux2_cell (
  input  logic       s,
  input  logic [1:0] d,
  output logic       y
);

  assign y = s ? d[1] : d[0];

endmodule

module muxer_4 #(
  parameter int   N_IN    = 4,
  parameter int   SEL_W   = $clog2(N_IN),
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  output logic             q
);

  logic lo;
  logic hi;
  logic m;
  logic q_d;
  logic q_q;

  // Leaf cells: sel[0] picks within the low pair and within the high pair.
  mux2_cell u_leaf_lo (
    .s (sel[0]),
    .d (in[1:0]),
    .y (lo)
  );

  mux2_cell u_leaf_hi (
    .s (sel[0]),
    .d (in[3:2]),
    .y (hi)
  );

  // Root cell: sel[1] picks between the two halves.
  mux2_cell u_root (
    .s (sel[1]),
    .d ({hi, lo}),
    .y (m)
  );

  // Next value of the output register is the tree result.
  always_comb begin
    q_d = m;
  end

  // Output register; reset wins over any data or select on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_muxer_4.sv
// Directed bench for muxer_4 and its 2:1 cell.
// Inputs change on the falling edge; q is sampled 1 ns after the rising edge.
module tb_muxer_4;

  logic       clk;
  logic       rst;
  logic [3:0] inBus;
  logic [1:0] selBus;
  logic       q;

  logic       cellS;
  logic [1:0] cellD;
  logic       cellY;

  int checks;
  int errors;

  muxer_4 dut (
    .clk (clk),
    .rst (rst),
    .in  (inBus),
    .sel (selBus),
    .q   (q)
  );

  mux2_cell u_cell (
    .s (cellS),
    .d (cellD),
    .y (cellY)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one input set on the falling edge, then wait past the next
  // rising edge so the registered result can be sampled.
  task automatic applyStimulus(input logic r, input logic [3:0] i, input logic [1:0] s);
    @(negedge clk);
    rst    = r;
    inBus  = i;
    selBus = s;
    @(posedge clk);
    #1;
  endtask

  // Compare an observed bit against its expected value.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    logic [3:0] vecIn;
    logic [1:0] vecSel;
    logic       expBit;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    inBus  = 4'hF;
    selBus = 2'd3;
    cellS  = 1'b0;
    cellD  = 2'b00;

    // Reset held for two edges with a selected 1 on the bus.
    applyStimulus(1'b1, 4'hF, 2'd3);
    checkOutput("reset_edge1", q, 1'b0);
    applyStimulus(1'b1, 4'hF, 2'd3);
    checkOutput("reset_edge2", q, 1'b0);
    applyStimulus(1'b0, 4'hF, 2'd3);
    checkOutput("reset_release", q, 1'b1);

    // Walking one: selected bit is always the single 1.
    applyStimulus(1'b0, 4'h1, 2'd0);
    checkOutput("walk1_sel0", q, 1'b1);
    applyStimulus(1'b0, 4'h2, 2'd1);
    checkOutput("walk1_sel1", q, 1'b1);
    applyStimulus(1'b0, 4'h4, 2'd2);
    checkOutput("walk1_sel2", q, 1'b1);
    applyStimulus(1'b0, 4'h8, 2'd3);
    checkOutput("walk1_sel3", q, 1'b1);

    // Walking zero: selected bit is always the single 0.
    applyStimulus(1'b0, 4'hE, 2'd0);
    checkOutput("walk0_sel0", q, 1'b0);
    applyStimulus(1'b0, 4'hD, 2'd1);
    checkOutput("walk0_sel1", q, 1'b0);
    applyStimulus(1'b0, 4'hB, 2'd2);
    checkOutput("walk0_sel2", q, 1'b0);
    applyStimulus(1'b0, 4'h7, 2'd3);
    checkOutput("walk0_sel3", q, 1'b0);

    // Latency: new inputs are not visible before the edge that samples them.
    @(negedge clk);
    inBus  = 4'h1;
    selBus = 2'd0;
    #1;
    checkOutput("latency_hold", q, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("latency_update", q, 1'b1);

    // Isolation: sel=2 with in[2]=1, unselected bits toggling.
    applyStimulus(1'b0, 4'b0100, 2'd2);
    checkOutput("iso_base", q, 1'b1);
    applyStimulus(1'b0, 4'b0101, 2'd2);
    checkOutput("iso_in0", q, 1'b1);
    applyStimulus(1'b0, 4'b0111, 2'd2);
    checkOutput("iso_in1", q, 1'b1);
    applyStimulus(1'b0, 4'b1111, 2'd2);
    checkOutput("iso_in3", q, 1'b1);
    applyStimulus(1'b0, 4'b1100, 2'd2);
    checkOutput("iso_mix", q, 1'b1);
    applyStimulus(1'b0, 4'b1011, 2'd2);
    checkOutput("iso_in2_low", q, 1'b0);

    // Standalone 2:1 cell truth table.
    cellS = 1'b0; cellD = 2'b01; #1;
    checkOutput("cell_s0_d01", cellY, 1'b1);
    cellS = 1'b0; cellD = 2'b10; #1;
    checkOutput("cell_s0_d10", cellY, 1'b0);
    cellS = 1'b1; cellD = 2'b10; #1;
    checkOutput("cell_s1_d10", cellY, 1'b1);
    cellS = 1'b1; cellD = 2'b01; #1;
    checkOutput("cell_s1_d01", cellY, 1'b0);

    // Exhaustive sweep of {sel,in}, with one reset edge in the middle.
    for (int idx = 0; idx < 64; idx++) begin
      vecSel = idx[5:4];
      vecIn  = idx[3:0];
      if (idx == 32) begin
        applyStimulus(1'b1, 4'hF, vecSel);
        checkOutput("exh_mid_reset", q, 1'b0);
      end
      expBit = (vecIn >> vecSel) & 4'h1;
      applyStimulus(1'b0, vecIn, vecSel);
      checkOutput($sformatf("exh_sel%0d_in%h", vecSel, vecIn), q, expBit);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
